usb_rx_pkt_ctrl: RTL and testbench

USB_RX_PKT_CTRL -- requirements
Module: usb_rx_pkt_ctrl

---
 rtl/usb_rx_pkt_ctrl_if.sv | 30 +++
 rtl/usb_rx_pkt_ctrl.sv | 138 +++++++++++++
 tb/tb_usb_rx_pkt_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkt_ctrl_if.sv
// Handshake and status bundle between the USB receive decoder, the
// packet controller and the downstream FIFO.
interface usb_rx_pkt_ctrl_if #(
    parameter int unsigned CNT_W = 7
);
    logic             d_edge;
    logic             eop;
    logic             shift_enable;
    logic             byte_received;
    logic [7:0]       rcv_data;
    logic             fifo_full;
    logic             rcving;
    logic             w_enable;
    logic             r_error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] byte_count;
    logic             pkt_done;

    // Decoder / FIFO side: supplies line events and bytes, observes status.
    modport master (
        output d_edge, eop, shift_enable, byte_received, rcv_data, fifo_full,
        input  rcving, w_enable, r_error, err_code, byte_count, pkt_done
    );

    // Controller side.
    modport slave (
        input  d_edge, eop, shift_enable, byte_received, rcv_data, fifo_full,
        output rcving, w_enable, r_error, err_code, byte_count, pkt_done
    );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// USB receive packet controller: checks the sync byte, writes data bytes
// to the FIFO, tracks packet length and latches the first receive error.
module usb_rx_pkt_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'h7F,
    parameter int unsigned MAX_BYTES = 64,
    parameter int unsigned CNT_W     = 7
) (
    input logic              clk,
    input logic              n_rst,
    usb_rx_pkt_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SYNC_WAIT  = 4'd1,
        SYNC_CHECK = 4'd2,
        DATA       = 4'd3,
        WRITE      = 4'd4,
        EOB        = 4'd5,
        END_WAIT   = 4'd6,
        ERR_DRAIN  = 4'd7,
        ERR_IDLE   = 4'd8
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] count_q, next_count;
    logic [1:0]       code_q, next_code;
    logic             armed_q, next_armed;

    // State, byte count, error code and idle-return arm flag registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            count_q <= '0;
            code_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state   <= next_state;
            count_q <= next_count;
            code_q  <= next_code;
            armed_q <= next_armed;
        end
    end

    // Next-state, next register values and combinational outputs.
    always_comb begin
        next_state       = state;
        next_count       = count_q;
        next_code        = code_q;
        next_armed       = 1'b0;
        bus.rcving       = 1'b0;
        bus.w_enable     = 1'b0;
        bus.r_error      = 1'b0;
        bus.pkt_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.d_edge) begin
                    next_state = SYNC_WAIT;
                    next_count = '0;
                end
            end
            SYNC_WAIT: begin
                bus.rcving = 1'b1;
                if (bus.byte_received) next_state = SYNC_CHECK;
            end
            SYNC_CHECK: begin
                bus.rcving = 1'b1;
                if (bus.rcv_data == SYNC_BYTE) begin
                    next_state = DATA;
                end else begin
                    next_state = ERR_DRAIN;
                    next_code  = 2'b01;
                end
            end
            DATA: begin
                bus.rcving = 1'b1;
                if (bus.eop && bus.shift_enable) begin
                    next_state = ERR_DRAIN;
                    next_code  = 2'b10;
                end else if (bus.byte_received && (count_q == MAX_CNT || bus.fifo_full)) begin
                    next_state = ERR_DRAIN;
                    next_code  = 2'b11;
                end else if (bus.byte_received) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                bus.rcving   = 1'b1;
                bus.w_enable = 1'b1;
                if (count_q != MAX_CNT) next_count = count_q + CNT_W'(1);
                next_state = EOB;
            end
            EOB: begin
                bus.rcving = 1'b1;
                if (bus.shift_enable) begin
                    if (bus.eop) begin
                        next_state   = END_WAIT;
                        bus.pkt_done = 1'b1;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            END_WAIT: begin
                if (bus.d_edge) next_state = IDLE;
            end
            ERR_DRAIN: begin
                bus.rcving  = 1'b1;
                bus.r_error = 1'b1;
                if (bus.eop && bus.shift_enable) next_state = ERR_IDLE;
            end
            ERR_IDLE: begin
                bus.r_error = 1'b1;
                next_armed  = armed_q;
                // First edge is the bus going idle; the second starts a new packet.
                if (bus.d_edge) begin
                    if (armed_q) begin
                        next_state = SYNC_WAIT;
                        next_code  = '0;
                        next_count = '0;
                        next_armed = 1'b0;
                    end else begin
                        next_armed = 1'b1;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_count = '0;
                next_code  = '0;
            end
        endcase
    end

    assign bus.byte_count = count_q;
    assign bus.err_code   = code_q;
endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Scoreboard bench for usb_rx_pkt_ctrl with a short length limit.
module tb_usb_rx_pkt_ctrl;
    localparam int unsigned CNT_W = 7;
    localparam logic [7:0]  SYNC  = 8'h7F;

    logic clk;
    logic n_rst;
    int   total = 0;
    int   bad   = 0;

    typedef struct packed {
        logic [1:0]  kind;  // 0 write, 1 packet done, 2 error entry
        logic [15:0] val;
    } evt_t;

    evt_t exp_q[$];

    usb_rx_pkt_ctrl_if #(.CNT_W(CNT_W)) bus ();

    usb_rx_pkt_ctrl #(
        .SYNC_BYTE(SYNC),
        .MAX_BYTES(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push(input logic [1:0] k, input logic [15:0] v);
        evt_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic void check_evt(input logic [1:0] k, input logic [15:0] v);
        evt_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL evt_unexpected: got kind=%0d val=%h, required none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                bad++;
                $display("FAIL evt_order: got kind=%0d val=%h, required kind=%0d val=%h",
                         k, v, e.kind, e.val);
            end
        end
    endfunction

    // Monitor: compares every write, packet end and error entry against the queue.
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        if (n_rst) begin
            if (bus.w_enable) check_evt(2'd0, {1'b0, bus.byte_count, bus.rcv_data});
            if (bus.pkt_done) check_evt(2'd1, {9'd0, bus.byte_count});
            if (bus.r_error && !prev_err) check_evt(2'd2, {14'd0, bus.err_code});
        end
        prev_err = bus.r_error;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_edge();
        bus.d_edge = 1'b1;
        tick();
        bus.d_edge = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rcv_data      = b;
        bus.byte_received = 1'b1;
        tick();
        bus.byte_received = 1'b0;
        tick();
    endtask

    task automatic strobe(input logic e);
        bus.eop          = e;
        bus.shift_enable = 1'b1;
        tick();
        bus.shift_enable = 1'b0;
    endtask

    // Sync plus n data bytes and a byte-aligned EOP, starting in SYNC_WAIT.
    task automatic pkt_body(input int n);
        logic [7:0] d;
        send_byte(SYNC);
        for (int i = 0; i < n; i++) begin
            d = 8'hA0 + 8'(i);
            push(2'd0, {1'b0, 7'(i), d});
            send_byte(d);
            if (i == n - 1) push(2'd1, 16'(n));
            strobe(i == n - 1);
        end
        chk("end_rcving", {15'd0, bus.rcving}, 16'd0);
        chk("end_count", {9'd0, bus.byte_count}, 16'(n));
        chk("end_rerr", {15'd0, bus.r_error}, 16'd0);
        bus.eop = 1'b0;
        pulse_edge();
        chk("idle_count_hold", {9'd0, bus.byte_count}, 16'(n));
    endtask

    // Drain an error, check it is sticky through the first idle edge, recover.
    task automatic err_recover(input logic [1:0] code, input int cnt);
        chk("drain_count", {9'd0, bus.byte_count}, 16'(cnt));
        strobe(1'b1);
        chk("erridle_rerr", {15'd0, bus.r_error}, 16'd1);
        chk("erridle_rcving", {15'd0, bus.rcving}, 16'd0);
        bus.eop = 1'b0;
        pulse_edge();
        chk("armed_rerr", {15'd0, bus.r_error}, 16'd1);
        chk("armed_code", {14'd0, bus.err_code}, {14'd0, code});
        pulse_edge();
        chk("recov_rerr", {15'd0, bus.r_error}, 16'd0);
        chk("recov_code", {14'd0, bus.err_code}, 16'd0);
        chk("recov_count", {9'd0, bus.byte_count}, 16'd0);
        chk("recov_rcving", {15'd0, bus.rcving}, 16'd1);
        pkt_body(2);
    endtask

    initial begin
        n_rst             = 1'b0;
        bus.d_edge        = 1'b0;
        bus.eop           = 1'b0;
        bus.shift_enable  = 1'b0;
        bus.byte_received = 1'b0;
        bus.rcv_data      = 8'h00;
        bus.fifo_full     = 1'b0;
        #1;
        chk("rst_outputs", {bus.rcving, bus.w_enable, bus.r_error, bus.pkt_done,
                            bus.err_code, 3'd0, bus.byte_count}, 16'd0);
        tick();
        tick();
        n_rst = 1'b1;
        tick();

        // Clean 3-byte packet.
        pulse_edge();
        pkt_body(3);

        // Bad sync byte.
        pulse_edge();
        push(2'd2, 16'd1);
        send_byte(8'h55);
        err_recover(2'b01, 0);

        // EOP in the middle of a data byte.
        pulse_edge();
        send_byte(SYNC);
        push(2'd0, {1'b0, 7'd0, 8'h31});
        send_byte(8'h31);
        strobe(1'b0);
        push(2'd2, 16'd2);
        strobe(1'b1);
        err_recover(2'b10, 1);

        // Length overrun: fifth data byte with a limit of four.
        pulse_edge();
        send_byte(SYNC);
        for (int i = 0; i < 4; i++) begin
            push(2'd0, {1'b0, 7'(i), 8'h40 + 8'(i)});
            send_byte(8'h40 + 8'(i));
            strobe(1'b0);
        end
        chk("sat_count", {9'd0, bus.byte_count}, 16'd4);
        push(2'd2, 16'd3);
        send_byte(8'h44);
        err_recover(2'b11, 4);

        // FIFO full at the second data byte.
        pulse_edge();
        send_byte(SYNC);
        push(2'd0, {1'b0, 7'd0, 8'h61});
        send_byte(8'h61);
        strobe(1'b0);
        bus.fifo_full = 1'b1;
        push(2'd2, 16'd3);
        send_byte(8'h62);
        bus.fifo_full = 1'b0;
        err_recover(2'b11, 1);

        // Reset while a write is in progress.
        pulse_edge();
        send_byte(SYNC);
        push(2'd0, {1'b0, 7'd0, 8'h11});
        send_byte(8'h11);
        strobe(1'b0);
        bus.rcv_data      = 8'h22;
        bus.byte_received = 1'b1;
        tick();
        bus.byte_received = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("midrst_outputs", {bus.rcving, bus.w_enable, bus.r_error, bus.pkt_done,
                               bus.err_code, 3'd0, bus.byte_count}, 16'd0);
        tick();
        n_rst = 1'b1;
        tick();
        pulse_edge();
        pkt_body(3);

        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL evt_missing: got %0d outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
